// File: rtl/ctrl_pipe_unit.sv
// ID/EX control-decode register for the LEGv8-style pipeline: decodes opcode[31:21]
// into the registered control bundle and sequences multi-cycle MUL issue.
module ctrl_pipe_unit #(
  parameter int MUL_LAT        = 4,
  parameter int ILLEGAL_BUBBLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [10:0] opcode,
  input  logic        stall_in,
  input  logic        flush_in,
  output logic [17:0] ctrl,
  output logic        ctrl_valid,
  output logic        busy,
  output logic        illegal
);

  typedef enum logic {IDLE, MULBUSY} state_t;

  localparam logic [3:0] CNT_LOAD  = 4'(MUL_LAT - 1);
  localparam bit         MUL_MULTI = (MUL_LAT > 1);
  localparam bit         ILL_VLD   = (ILLEGAL_BUBBLE == 0);

  // Bundle layout, MSB first:
  // Reg2Loc RegWrite ALUSrc ALUOp[2:0] MemWrite MemRead MemToReg SetFlags
  // CBZ BL BLT BR B ImmSel[1:0] MulStart
  function automatic logic [18:0] decode(input logic [10:0] op);
    logic [18:0] r;
    r = '0;
    casez (op)
      11'b1001000100?: r = {1'b1, 18'b0_1_1_010_0_0_0_0_0_0_0_0_0_00_0}; // ADDI
      11'b10101011000: r = {1'b1, 18'b0_1_0_010_0_0_0_1_0_0_0_0_0_00_0}; // ADDS
      11'b11101011000: r = {1'b1, 18'b0_1_0_011_0_0_0_1_0_0_0_0_0_00_0}; // SUBS
      11'b11111000010: r = {1'b1, 18'b0_1_1_010_0_1_1_0_0_0_0_0_0_11_0}; // LDUR
      11'b11111000000: r = {1'b1, 18'b1_0_1_010_1_0_0_0_0_0_0_0_0_11_0}; // STUR
      11'b10110100???: r = {1'b1, 18'b1_0_0_000_0_0_0_0_1_0_0_0_0_10_0}; // CBZ
      11'b000101?????: r = {1'b1, 18'b0_0_0_000_0_0_0_0_0_0_0_0_1_01_0}; // B
      11'b100101?????: r = {1'b1, 18'b0_1_0_000_0_0_0_0_0_1_0_0_0_01_0}; // BL
      11'b01010100???: r = {1'b1, 18'b0_0_0_000_0_0_0_0_0_0_1_0_0_10_0}; // B.cond
      11'b11010110000: r = {1'b1, 18'b1_0_0_000_0_0_0_0_0_0_0_1_0_00_0}; // BR
      11'b10011011000: r = {1'b1, 18'b0_1_0_100_0_0_0_0_0_0_0_0_0_00_1}; // MUL
      default:         r = '0;
    endcase
    return r;
  endfunction

  // Stage p0: combinational decode of the presented opcode
  logic [17:0] dec_p0;
  logic        hit_p0;

  always_comb begin
    {hit_p0, dec_p0} = decode(opcode);
  end

  // Stage p1: ID/EX register and MUL sequencer
  state_t      state;
  logic [3:0]  cnt;
  logic [17:0] ctrl_p1;
  logic        vld_p1;
  logic        busy_p1;
  logic        ill_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      ctrl_p1 <= '0;
      vld_p1  <= 1'b0;
      busy_p1 <= 1'b0;
      ill_p1  <= 1'b0;
    end else if (flush_in) begin
      state   <= IDLE;
      cnt     <= '0;
      ctrl_p1 <= '0;
      vld_p1  <= 1'b0;
      busy_p1 <= 1'b0;
      ill_p1  <= 1'b0;
    end else if (state == MULBUSY) begin
      ctrl_p1 <= '0;
      vld_p1  <= 1'b0;
      ill_p1  <= 1'b0;
      cnt     <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        state   <= IDLE;
        busy_p1 <= 1'b0;
      end
    end else if (stall_in) begin
      // Held bundle keeps its fields, but MulStart must not fire twice
      ctrl_p1[0] <= 1'b0;
      ill_p1     <= 1'b0;
      busy_p1    <= 1'b0;
    end else begin
      busy_p1 <= 1'b0;
      if (!instr_valid) begin
        ctrl_p1 <= '0;
        vld_p1  <= 1'b0;
        ill_p1  <= 1'b0;
      end else if (hit_p0) begin
        ctrl_p1 <= dec_p0;
        vld_p1  <= 1'b1;
        ill_p1  <= 1'b0;
        if (dec_p0[0] && MUL_MULTI) begin
          state   <= MULBUSY;
          cnt     <= CNT_LOAD;
          busy_p1 <= 1'b1;
        end
      end else begin
        ctrl_p1 <= '0;
        vld_p1  <= ILL_VLD;
        ill_p1  <= 1'b1;
      end
    end
  end

  assign ctrl       = ctrl_p1;
  assign ctrl_valid = vld_p1;
  assign busy       = busy_p1;
  assign illegal    = ill_p1;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Scoreboard bench for ctrl_pipe_unit: default build (MUL_LAT=4, bubble on illegal)
// plus a MUL_LAT=1 / ILLEGAL_BUBBLE=0 build driven from the same inputs.
module tb_ctrl_pipe_unit;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [10:0] opcode;
  logic        stall_in;
  logic        flush_in;
  logic [17:0] ctrl,   ctrl_b;
  logic        ctrl_valid, ctrl_valid_b;
  logic        busy,   busy_b;
  logic        illegal, illegal_b;

  ctrl_pipe_unit #(.MUL_LAT(4), .ILLEGAL_BUBBLE(1)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
    .stall_in(stall_in), .flush_in(flush_in),
    .ctrl(ctrl), .ctrl_valid(ctrl_valid), .busy(busy), .illegal(illegal)
  );

  ctrl_pipe_unit #(.MUL_LAT(1), .ILLEGAL_BUBBLE(0)) dut_b (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
    .stall_in(stall_in), .flush_in(flush_in),
    .ctrl(ctrl_b), .ctrl_valid(ctrl_valid_b), .busy(busy_b), .illegal(illegal_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [17:0] c;
    logic        v;
    logic        b;
    logic        i;
  } obs_t;

  typedef struct {
    logic        r;
    logic        iv;
    logic [10:0] op;
    logic        st;
    logic        fl;
    obs_t        e;
  } step_t;

  // Field masks of the control bundle
  localparam logic [17:0] M_R2L = 18'd1 << 17;
  localparam logic [17:0] M_RW  = 18'd1 << 16;
  localparam logic [17:0] M_AS  = 18'd1 << 15;
  localparam logic [17:0] M_MW  = 18'd1 << 11;
  localparam logic [17:0] M_MR  = 18'd1 << 10;
  localparam logic [17:0] M_M2R = 18'd1 << 9;
  localparam logic [17:0] M_SF  = 18'd1 << 8;
  localparam logic [17:0] M_CBZ = 18'd1 << 7;
  localparam logic [17:0] M_BL  = 18'd1 << 6;
  localparam logic [17:0] M_BLT = 18'd1 << 5;
  localparam logic [17:0] M_BR  = 18'd1 << 4;
  localparam logic [17:0] M_B   = 18'd1 << 3;
  localparam logic [17:0] M_MS  = 18'd1;

  localparam logic [17:0] E_ADDI  = M_RW | M_AS | (18'd2 << 12);
  localparam logic [17:0] E_ADDS  = M_RW | (18'd2 << 12) | M_SF;
  localparam logic [17:0] E_SUBS  = M_RW | (18'd3 << 12) | M_SF;
  localparam logic [17:0] E_LDUR  = M_RW | M_AS | (18'd2 << 12) | M_MR | M_M2R | (18'd3 << 1);
  localparam logic [17:0] E_STUR  = M_R2L | M_AS | (18'd2 << 12) | M_MW | (18'd3 << 1);
  localparam logic [17:0] E_CBZ   = M_R2L | M_CBZ | (18'd2 << 1);
  localparam logic [17:0] E_B     = M_B | (18'd1 << 1);
  localparam logic [17:0] E_BL    = M_RW | M_BL | (18'd1 << 1);
  localparam logic [17:0] E_BCOND = M_BLT | (18'd2 << 1);
  localparam logic [17:0] E_BR    = M_R2L | M_BR;
  localparam logic [17:0] E_MUL   = M_RW | (18'd4 << 12) | M_MS;

  localparam logic [10:0] OP_ADDI  = 11'b10010001001;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [10:0] OP_CBZ   = 11'b10110100101;
  localparam logic [10:0] OP_B     = 11'b00010110011;
  localparam logic [10:0] OP_BL    = 11'b10010111111;
  localparam logic [10:0] OP_BCOND = 11'b01010100011;
  localparam logic [10:0] OP_BR    = 11'b11010110000;
  localparam logic [10:0] OP_MUL   = 11'b10011011000;
  localparam logic [10:0] OP_ILL   = 11'b00000000000;

  obs_t exp_q[$];
  obs_t expb_q[$];
  int   pass_cnt;
  int   total_cnt;

  function automatic obs_t mk(input logic [17:0] c, input logic v, input logic b, input logic i);
    return {c, v, b, i};
  endfunction

  function automatic step_t S(input logic r, input logic iv, input logic [10:0] op,
                              input logic st, input logic fl, input obs_t e);
    step_t s;
    s.r = r; s.iv = iv; s.op = op; s.st = st; s.fl = fl; s.e = e;
    return s;
  endfunction

  task automatic drive(input step_t s);
    reset       = s.r;
    instr_valid = s.iv;
    opcode      = s.op;
    stall_in    = s.st;
    flush_in    = s.fl;
  endtask

  task automatic test_reset();
    step_t s[$];
    obs_t got, want;
    s.push_back(S(1, 1, OP_ADDI, 0, 0, mk('0, 0, 0, 0)));
    s.push_back(S(1, 1, OP_MUL,  0, 0, mk('0, 0, 0, 0)));
    s.push_back(S(0, 1, OP_ADDI, 0, 0, mk(E_ADDI, 1, 0, 0)));
    foreach (s[k]) begin
      drive(s[k]); exp_q.push_back(s[k].e);
      @(posedge clk); #1;
      got = {ctrl, ctrl_valid, busy, illegal}; want = exp_q.pop_front();
      total_cnt++;
      if (got !== want)
        $display("FAIL reset[%0d] got ctrl=%h vld=%b busy=%b ill=%b, want ctrl=%h vld=%b busy=%b ill=%b",
                 k, got.c, got.v, got.b, got.i, want.c, want.v, want.b, want.i);
      else pass_cnt++;
    end
  endtask

  task automatic test_decode();
    step_t s[$];
    obs_t got, want;
    s.push_back(S(0, 1, OP_ADDI,  0, 0, mk(E_ADDI,  1, 0, 0)));
    s.push_back(S(0, 1, OP_ADDS,  0, 0, mk(E_ADDS,  1, 0, 0)));
    s.push_back(S(0, 1, OP_SUBS,  0, 0, mk(E_SUBS,  1, 0, 0)));
    s.push_back(S(0, 1, OP_LDUR,  0, 0, mk(E_LDUR,  1, 0, 0)));
    s.push_back(S(0, 1, OP_STUR,  0, 0, mk(E_STUR,  1, 0, 0)));
    s.push_back(S(0, 1, OP_CBZ,   0, 0, mk(E_CBZ,   1, 0, 0)));
    s.push_back(S(0, 1, OP_B,     0, 0, mk(E_B,     1, 0, 0)));
    s.push_back(S(0, 1, OP_BL,    0, 0, mk(E_BL,    1, 0, 0)));
    s.push_back(S(0, 1, OP_BCOND, 0, 0, mk(E_BCOND, 1, 0, 0)));
    s.push_back(S(0, 1, OP_BR,    0, 0, mk(E_BR,    1, 0, 0)));
    s.push_back(S(0, 0, OP_ADDS,  0, 0, mk('0,      0, 0, 0)));
    foreach (s[k]) begin
      drive(s[k]); exp_q.push_back(s[k].e);
      @(posedge clk); #1;
      got = {ctrl, ctrl_valid, busy, illegal}; want = exp_q.pop_front();
      total_cnt++;
      if (got !== want)
        $display("FAIL decode[%0d] got ctrl=%h vld=%b busy=%b ill=%b, want ctrl=%h vld=%b busy=%b ill=%b",
                 k, got.c, got.v, got.b, got.i, want.c, want.v, want.b, want.i);
      else pass_cnt++;
    end
  endtask

  task automatic test_mul();
    step_t s[$];
    obs_t got, want;
    s.push_back(S(0, 1, OP_MUL,  0, 0, mk(E_MUL, 1, 1, 0)));
    s.push_back(S(0, 1, OP_ADDS, 0, 0, mk('0, 0, 1, 0)));
    s.push_back(S(0, 1, OP_ADDS, 1, 0, mk('0, 0, 1, 0)));
    s.push_back(S(0, 1, OP_ADDS, 0, 0, mk('0, 0, 0, 0)));
    s.push_back(S(0, 1, OP_ADDS, 0, 0, mk(E_ADDS, 1, 0, 0)));
    foreach (s[k]) begin
      drive(s[k]); exp_q.push_back(s[k].e);
      @(posedge clk); #1;
      got = {ctrl, ctrl_valid, busy, illegal}; want = exp_q.pop_front();
      total_cnt++;
      if (got !== want)
        $display("FAIL mul[%0d] got ctrl=%h vld=%b busy=%b ill=%b, want ctrl=%h vld=%b busy=%b ill=%b",
                 k, got.c, got.v, got.b, got.i, want.c, want.v, want.b, want.i);
      else pass_cnt++;
    end
  endtask

  task automatic test_stall();
    step_t s[$];
    obs_t got, want;
    s.push_back(S(0, 1, OP_LDUR, 0, 0, mk(E_LDUR, 1, 0, 0)));
    s.push_back(S(0, 1, OP_SUBS, 1, 0, mk(E_LDUR, 1, 0, 0)));
    s.push_back(S(0, 1, OP_SUBS, 1, 0, mk(E_LDUR, 1, 0, 0)));
    s.push_back(S(0, 1, OP_SUBS, 1, 0, mk(E_LDUR, 1, 0, 0)));
    s.push_back(S(0, 1, OP_SUBS, 0, 0, mk(E_SUBS, 1, 0, 0)));
    foreach (s[k]) begin
      drive(s[k]); exp_q.push_back(s[k].e);
      @(posedge clk); #1;
      got = {ctrl, ctrl_valid, busy, illegal}; want = exp_q.pop_front();
      total_cnt++;
      if (got !== want)
        $display("FAIL stall[%0d] got ctrl=%h vld=%b busy=%b ill=%b, want ctrl=%h vld=%b busy=%b ill=%b",
                 k, got.c, got.v, got.b, got.i, want.c, want.v, want.b, want.i);
      else pass_cnt++;
    end
  endtask

  task automatic test_flush_busy();
    step_t s[$];
    obs_t got, want;
    s.push_back(S(0, 1, OP_MUL,  0, 0, mk(E_MUL, 1, 1, 0)));
    s.push_back(S(0, 0, OP_ADDI, 0, 0, mk('0, 0, 1, 0)));
    s.push_back(S(0, 1, OP_ADDI, 0, 1, mk('0, 0, 0, 0)));
    s.push_back(S(0, 1, OP_ADDI, 0, 0, mk(E_ADDI, 1, 0, 0)));
    s.push_back(S(0, 1, OP_ADDI, 0, 1, mk('0, 0, 0, 0)));
    foreach (s[k]) begin
      drive(s[k]); exp_q.push_back(s[k].e);
      @(posedge clk); #1;
      got = {ctrl, ctrl_valid, busy, illegal}; want = exp_q.pop_front();
      total_cnt++;
      if (got !== want)
        $display("FAIL flush[%0d] got ctrl=%h vld=%b busy=%b ill=%b, want ctrl=%h vld=%b busy=%b ill=%b",
                 k, got.c, got.v, got.b, got.i, want.c, want.v, want.b, want.i);
      else pass_cnt++;
    end
  endtask

  task automatic test_illegal();
    step_t s[$];
    obs_t got, want;
    s.push_back(S(0, 1, OP_ILL, 0, 0, mk('0, 0, 0, 1)));
    s.push_back(S(0, 0, OP_ILL, 0, 0, mk('0, 0, 0, 0)));
    s.push_back(S(0, 0, OP_ILL, 0, 0, mk('0, 0, 0, 0)));
    s.push_back(S(0, 1, OP_ILL, 0, 0, mk('0, 0, 0, 1)));
    s.push_back(S(0, 1, OP_ILL, 1, 0, mk('0, 0, 0, 0)));
    foreach (s[k]) begin
      drive(s[k]); exp_q.push_back(s[k].e);
      @(posedge clk); #1;
      got = {ctrl, ctrl_valid, busy, illegal}; want = exp_q.pop_front();
      total_cnt++;
      if (got !== want)
        $display("FAIL illegal[%0d] got ctrl=%h vld=%b busy=%b ill=%b, want ctrl=%h vld=%b busy=%b ill=%b",
                 k, got.c, got.v, got.b, got.i, want.c, want.v, want.b, want.i);
      else pass_cnt++;
    end
  endtask

  task automatic test_simultaneous();
    step_t s[$];
    obs_t got, want;
    s.push_back(S(0, 1, OP_ADDI, 0, 0, mk(E_ADDI, 1, 0, 0)));
    s.push_back(S(0, 1, OP_MUL,  1, 1, mk('0, 0, 0, 0)));
    s.push_back(S(0, 0, OP_MUL,  0, 0, mk('0, 0, 0, 0)));
    foreach (s[k]) begin
      drive(s[k]); exp_q.push_back(s[k].e);
      @(posedge clk); #1;
      got = {ctrl, ctrl_valid, busy, illegal}; want = exp_q.pop_front();
      total_cnt++;
      if (got !== want)
        $display("FAIL simul[%0d] got ctrl=%h vld=%b busy=%b ill=%b, want ctrl=%h vld=%b busy=%b ill=%b",
                 k, got.c, got.v, got.b, got.i, want.c, want.v, want.b, want.i);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_mul();
    step_t s[$];
    obs_t got, want;
    s.push_back(S(0, 1, OP_MUL,  0, 0, mk(E_MUL, 1, 1, 0)));
    s.push_back(S(0, 0, OP_MUL,  0, 0, mk('0, 0, 1, 0)));
    s.push_back(S(1, 0, OP_MUL,  0, 0, mk('0, 0, 0, 0)));
    s.push_back(S(0, 0, OP_MUL,  0, 0, mk('0, 0, 0, 0)));
    s.push_back(S(0, 1, OP_ADDS, 0, 0, mk(E_ADDS, 1, 0, 0)));
    foreach (s[k]) begin
      drive(s[k]); exp_q.push_back(s[k].e);
      @(posedge clk); #1;
      got = {ctrl, ctrl_valid, busy, illegal}; want = exp_q.pop_front();
      total_cnt++;
      if (got !== want)
        $display("FAIL rstmul[%0d] got ctrl=%h vld=%b busy=%b ill=%b, want ctrl=%h vld=%b busy=%b ill=%b",
                 k, got.c, got.v, got.b, got.i, want.c, want.v, want.b, want.i);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    step_t s;
    obs_t got, want;
    for (int k = 0; k < 24; k++) begin
      case ($urandom_range(0, 10))
        0:  s = S(0, 1, OP_ADDI,  0, 0, mk(E_ADDI,  1, 0, 0));
        1:  s = S(0, 1, OP_ADDS,  0, 0, mk(E_ADDS,  1, 0, 0));
        2:  s = S(0, 1, OP_SUBS,  0, 0, mk(E_SUBS,  1, 0, 0));
        3:  s = S(0, 1, OP_LDUR,  0, 0, mk(E_LDUR,  1, 0, 0));
        4:  s = S(0, 1, OP_STUR,  0, 0, mk(E_STUR,  1, 0, 0));
        5:  s = S(0, 1, OP_CBZ,   0, 0, mk(E_CBZ,   1, 0, 0));
        6:  s = S(0, 1, OP_B,     0, 0, mk(E_B,     1, 0, 0));
        7:  s = S(0, 1, OP_BL,    0, 0, mk(E_BL,    1, 0, 0));
        8:  s = S(0, 1, OP_BCOND, 0, 0, mk(E_BCOND, 1, 0, 0));
        9:  s = S(0, 1, OP_BR,    0, 0, mk(E_BR,    1, 0, 0));
        default: s = S(0, 0, OP_LDUR, 0, 0, mk('0,  0, 0, 0));
      endcase
      drive(s); exp_q.push_back(s.e);
      @(posedge clk); #1;
      got = {ctrl, ctrl_valid, busy, illegal}; want = exp_q.pop_front();
      total_cnt++;
      if (got !== want)
        $display("FAIL b2b[%0d] got ctrl=%h vld=%b busy=%b ill=%b, want ctrl=%h vld=%b busy=%b ill=%b",
                 k, got.c, got.v, got.b, got.i, want.c, want.v, want.b, want.i);
      else pass_cnt++;
    end
  endtask

  // Checks the MUL_LAT=1 / ILLEGAL_BUBBLE=0 build
  task automatic test_lat1();
    step_t s[$];
    obs_t got, want;
    s.push_back(S(1, 0, OP_MUL, 0, 0, mk('0, 0, 0, 0)));
    s.push_back(S(0, 1, OP_MUL, 0, 0, mk(E_MUL, 1, 0, 0)));
    s.push_back(S(0, 1, OP_MUL, 1, 0, mk(E_MUL & ~M_MS, 1, 0, 0)));
    s.push_back(S(0, 1, OP_MUL, 0, 0, mk(E_MUL, 1, 0, 0)));
    s.push_back(S(0, 0, OP_MUL, 0, 0, mk('0, 0, 0, 0)));
    s.push_back(S(0, 1, OP_ILL, 0, 0, mk('0, 1, 0, 1)));
    s.push_back(S(0, 1, OP_ILL, 1, 0, mk('0, 1, 0, 0)));
    s.push_back(S(0, 0, OP_ILL, 0, 0, mk('0, 0, 0, 0)));
    foreach (s[k]) begin
      drive(s[k]); expb_q.push_back(s[k].e);
      @(posedge clk); #1;
      got = {ctrl_b, ctrl_valid_b, busy_b, illegal_b}; want = expb_q.pop_front();
      total_cnt++;
      if (got !== want)
        $display("FAIL lat1[%0d] got ctrl=%h vld=%b busy=%b ill=%b, want ctrl=%h vld=%b busy=%b ill=%b",
                 k, got.c, got.v, got.b, got.i, want.c, want.v, want.b, want.i);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt    = 0;
    total_cnt   = 0;
    reset       = 1'b1;
    instr_valid = 1'b0;
    opcode      = '0;
    stall_in    = 1'b0;
    flush_in    = 1'b0;
    test_reset();
    test_decode();
    test_mul();
    test_stall();
    test_flush_busy();
    test_illegal();
    test_simultaneous();
    test_reset_mid_mul();
    test_back_to_back();
    test_lat1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_unit.md
CTRL_PIPE_UNIT -- requirements
Module: ctrl_pipe_unit

Interface
REQ-001 Parameter MUL_LAT, default 4, is the MUL execute latency in cycles; legal range 1..16.
REQ-002 Parameter ILLEGAL_BUBBLE, default 1: 1 = unrecognised opcode yields a bubble; 0 = it yields all-zero control with ctrl_valid=1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 instr_valid  input  1  opcode is a real instruction this cycle.
REQ-006 opcode  input  11  instruction bits [31:21].
REQ-007 stall_in  input  1  hazard-unit hold request for the ID/EX register.
REQ-008 flush_in  input  1  branch-taken/redirect flush.
REQ-009 ctrl  output  18  registered ID/EX control bundle, MSB first: Reg2Loc, RegWrite, ALUSrc, ALUOp[2:0], MemWrite, MemRead, MemToReg, SetFlags, CBZ, BL, BLT, BR, B, ImmSel[1:0], MulStart.
REQ-010 ctrl_valid  output  1  ctrl holds a real instruction (not a bubble).
REQ-011 busy  output  1  registered; multi-cycle MUL in progress; upstream holds the IF/ID stage.
REQ-012 illegal  output  1  registered one-cycle pulse: unrecognised opcode accepted.

Function
REQ-013 Decode (opcode -> bundle, all other fields 0):
- ADDI 1001000100?: RegWrite, ALUSrc, ALUOp=010.
- ADDS 10101011000: RegWrite, ALUOp=010, SetFlags.
- SUBS 11101011000: RegWrite, ALUOp=011, SetFlags.
- LDUR 11111000010: RegWrite, ALUSrc, ALUOp=010, MemRead, MemToReg, ImmSel=11.
- STUR 11111000000: Reg2Loc, ALUSrc, ALUOp=010, MemWrite, ImmSel=11.
- CBZ 10110100???: Reg2Loc, CBZ, ImmSel=10.
- B 000101?????: B, ImmSel=01.
- BL 100101?????: RegWrite, BL, ImmSel=01.
- B.cond 01010100???: BLT, ImmSel=10.
- BR 11010110000: Reg2Loc, BR.
- MUL 10011011000 (new): RegWrite, ALUOp=100, MulStart.
REQ-014 A bubble is ctrl=0 and ctrl_valid=0.
REQ-015 The FSM has two states, IDLE and MULBUSY, plus a 4-bit down-counter cnt.
REQ-016 Per-cycle priority is reset > flush_in > MULBUSY > stall_in > load.
REQ-017 flush_in=1: ctrl and ctrl_valid become a bubble, illegal=0, state goes to IDLE, cnt clears; this applies in any state.
REQ-018 IDLE, stall_in=1, no flush: ctrl, ctrl_valid and state hold; illegal=0.
REQ-019 IDLE load, instr_valid=0: next ctrl is a bubble.
REQ-020 IDLE load, instr_valid=1, recognised opcode: next ctrl is the decoded bundle and ctrl_valid=1; decode-to-output latency is 1 cycle.
REQ-021 IDLE load, unrecognised opcode: illegal=1 next cycle; ctrl follows REQ-002.
REQ-022 MUL loaded with MUL_LAT>1: state goes to MULBUSY and cnt=MUL_LAT-1.
REQ-023 MUL loaded with MUL_LAT=1: state stays IDLE and busy never asserts.
REQ-024 MULBUSY: busy=1, ctrl is a bubble, opcode and stall_in are ignored, and cnt decrements each cycle; at cnt=1 the next state is IDLE.
REQ-025 Net MUL timing: busy is high exactly MUL_LAT-1 cycles, starting the cycle ctrl shows MulStart=1.
REQ-026 MulStart is 1 for exactly one cycle per accepted MUL; a held MUL under stall_in does not re-issue.
REQ-027 busy, illegal and ctrl_valid are driven only from flops; there is no combinational input-to-output path.

Reset
REQ-028 With reset=1 at a clock edge: ctrl=0, ctrl_valid=0, busy=0, illegal=0, state=IDLE, cnt=0.
REQ-029 reset=1 mid-MULBUSY aborts the MUL: no further busy cycle and no MulStart.
REQ-030 The first instruction after reset deasserts is decodable in the next cycle.

Verification
REQ-031 Decode sweep: each REQ-013 opcode with instr_valid=1, one per cycle -> each exact bundle one cycle later with ctrl_valid=1.
REQ-032 MUL with MUL_LAT=4: 10011011000 accepted at cycle N -> ctrl ALUOp=100, MulStart=1 at N+1; busy=1 at N+1..N+3; bubbles at N+2..N+3; next opcode decoded at N+4.
REQ-033 Stall hold: LDUR loaded, then stall_in=1 for 3 cycles while opcode changes to SUBS -> ctrl holds the LDUR bundle; SUBS appears 1 cycle after stall drops.
REQ-034 Flush in MULBUSY: flush_in=1 at second busy cycle -> next cycle busy=0, ctrl_valid=0, state IDLE.
REQ-035 Illegal: opcode 00000000000 with ILLEGAL_BUBBLE=1 -> illegal=1 for one cycle, ctrl_valid=0; same opcode with instr_valid=0 -> illegal stays 0.
REQ-036 Simultaneous events: flush_in=1, stall_in=1 and MUL in the same cycle -> bubble, busy=0, no MulStart; MUL_LAT=1 build -> MUL never raises busy.
